// File: rtl/fifo_ring.sv
// Circular-buffer FIFO with valid/ready on both sides, optional fall-through
// when empty, occupancy count, almost-full/almost-empty flags and flush.
module fifo_ring #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int BYPASS     = 1,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         i_valid,
  output logic                         i_ready,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         almost_full,
  output logic                         almost_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_ring: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic w_gate;
  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_push;
  logic w_pop;
  logic w_wr;
  logic w_rd;

  // Full is taken from the count register, so a pop in the full cycle cannot
  // open i_ready combinationally; this also keeps o_ready off the i_ready path.
  assign w_gate   = rst | flush;
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_LVL);
  assign w_bypass = (BYPASS != 0) && w_empty;

  assign i_ready = ~w_gate & ~w_full;
  assign o_valid = ~w_gate & (w_bypass ? i_valid : ~w_empty);
  assign o_data  = w_bypass ? i_data : r_mem[r_rd_ptr];

  assign w_push = i_valid & i_ready;
  assign w_pop  = o_valid & o_ready;

  // A fall-through transfer (empty, bypass, consumer ready) touches no state.
  assign w_wr = w_push & ~(w_bypass & w_pop);
  assign w_rd = w_pop & ~w_bypass;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr && !w_rd) begin
        r_count <= r_count + 1'b1;
      end else if (w_rd && !w_wr) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign count        = r_count;
  assign almost_full  = (r_count >= AF_LVL);
  assign almost_empty = (r_count <= AE_LVL);

endmodule

// File: tb/tb_fifo_ring.sv
// Self-checking bench for fifo_ring: a queue scoreboard follows the bypass DUT
// every cycle; a second, registered-path DUT covers the non-bypass latency.
module tb_fifo_ring;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       i_valid;
  logic       i_ready;
  logic [7:0] i_data;
  logic       o_valid;
  logic       o_ready;
  logic [7:0] o_data;
  logic [2:0] count;
  logic       almost_full;
  logic       almost_empty;

  logic       b_flush;
  logic       b_i_valid;
  logic       b_i_ready;
  logic [7:0] b_i_data;
  logic       b_o_valid;
  logic       b_o_ready;
  logic [7:0] b_o_data;
  logic [2:0] b_count;
  logic       b_almost_full;
  logic       b_almost_empty;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fifo_ring #(.DATA_WIDTH(8), .DEPTH(4), .BYPASS(1), .AF_THRESH(3), .AE_THRESH(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  fifo_ring #(.DATA_WIDTH(8), .DEPTH(4), .BYPASS(0), .AF_THRESH(3), .AE_THRESH(1)) dut_nb (
    .clk(clk), .rst(rst), .flush(b_flush),
    .i_valid(b_i_valid), .i_ready(b_i_ready), .i_data(b_i_data),
    .o_valid(b_o_valid), .o_ready(b_o_ready), .o_data(b_o_data),
    .count(b_count), .almost_full(b_almost_full), .almost_empty(b_almost_empty)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard for the bypass DUT: expected words are queued at each accepted
  // push and compared whenever the FIFO presents data.
  logic [7:0] exp_q[$];
  int         m_count = 0;
  logic       e_ready, e_valid, e_byp, e_push, e_pop;
  logic [7:0] e_data;

  always @(negedge clk) begin
    e_byp   = (m_count == 0);
    e_ready = !rst && !flush && (m_count != 4);
    e_valid = !rst && !flush && (e_byp ? i_valid : 1'b1);
    chk("i_ready", i_ready, e_ready);
    chk("o_valid", o_valid, e_valid);
    chk("count", count, m_count);
    chk("almost_full", almost_full, m_count >= 3);
    chk("almost_empty", almost_empty, m_count <= 1);
    e_push = i_valid && e_ready;
    e_pop  = e_valid && o_ready;
    if (e_valid) begin
      e_data = e_byp ? i_data : exp_q[0];
      chk("o_data", o_data, e_data);
    end
    if (rst || flush) begin
      exp_q.delete();
    end else begin
      if (e_pop && !e_byp) void'(exp_q.pop_front());
      if (e_push && !(e_pop && e_byp)) exp_q.push_back(i_data);
    end
    m_count = exp_q.size();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; i_valid = 1'b0; i_data = 8'h00; o_ready = 1'b0;
    b_flush = 1'b0; b_i_valid = 1'b0; b_i_data = 8'h00; b_o_ready = 1'b0;
    tick();
    rst = 1'b0;

    // Fill to full with the consumer stalled, then hold off a fifth word.
    for (int i = 1; i <= 4; i++) begin
      i_valid = 1'b1; i_data = 8'(i * 8'h11);
      tick();
    end
    i_data = 8'h55;
    @(negedge clk);
    chk("full_count", count, 3'd4);
    chk("full_hold", i_ready, 1'b0);
    tick();
    tick();

    // Drain four words in order; i_ready stays low in the first pop cycle.
    i_valid = 1'b0; o_ready = 1'b1;
    @(negedge clk);
    chk("pop_full_ready", i_ready, 1'b0);
    chk("first_out", o_data, 8'h11);
    repeat (4) tick();

    // Two resident words, then six cycles of simultaneous push/pop across the wrap.
    o_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1; i_data = 8'(8'h5E + i);
      tick();
    end
    o_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      i_data = 8'(8'h60 + i);
      tick();
    end
    @(negedge clk);
    chk("steady_count", count, 3'd2);
    i_valid = 1'b0;
    tick();
    tick();

    // Fall-through with a ready consumer: same-cycle output, nothing stored.
    i_valid = 1'b1; i_data = 8'hA5; o_ready = 1'b1;
    @(negedge clk);
    chk("byp_valid", o_valid, 1'b1);
    chk("byp_data", o_data, 8'hA5);
    tick();
    i_valid = 1'b0;
    @(negedge clk);
    chk("byp_count", count, 3'd0);

    // Fall-through with a stalled consumer: the word is stored.
    i_valid = 1'b1; o_ready = 1'b0;
    tick();
    i_valid = 1'b0; o_ready = 1'b1;
    @(negedge clk);
    chk("byp_store_count", count, 3'd1);
    chk("byp_store_data", o_data, 8'hA5);
    tick();

    // Registered path: no output in the push cycle, word appears next cycle.
    b_i_valid = 1'b1; b_i_data = 8'hA5; b_o_ready = 1'b1;
    @(negedge clk);
    chk("nb_push_valid", b_o_valid, 1'b0);
    tick();
    b_i_valid = 1'b0;
    @(negedge clk);
    chk("nb_next_valid", b_o_valid, 1'b1);
    chk("nb_next_data", b_o_data, 8'hA5);
    chk("nb_next_count", b_count, 3'd1);
    tick();
    @(negedge clk);
    chk("nb_drained", b_count, 3'd0);

    // Flush with three resident words and a concurrent push attempt.
    o_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      i_valid = 1'b1; i_data = 8'(8'h70 + i);
      tick();
    end
    flush = 1'b1; i_data = 8'h77; o_ready = 1'b1;
    @(negedge clk);
    chk("flush_ready", i_ready, 1'b0);
    chk("flush_valid", o_valid, 1'b0);
    tick();
    flush = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    chk("flush_count", count, 3'd0);
    chk("flush_out", o_valid, 1'b0);
    tick();

    // Reset with two resident words while pushing; only post-reset data emerges.
    o_ready = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      i_valid = 1'b1; i_data = 8'(8'h80 + i);
      tick();
    end
    rst = 1'b1; i_data = 8'h83;
    tick();
    rst = 1'b0; i_data = 8'h12;
    @(negedge clk);
    chk("rst_count", count, 3'd0);
    tick();
    i_valid = 1'b0; o_ready = 1'b1;
    @(negedge clk);
    chk("rst_first", o_data, 8'h12);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_ring.md
Name: fifo_ring

Overview:
- Parametrised successor to the single-entry valid/ready buffer: a DEPTH-entry circular-buffer FIFO with valid/ready handshakes on both sides.
- Adds selectable fall-through bypass, occupancy count, almost-full/almost-empty flags and a synchronous flush.
- Sits between producer and consumer stages as an elastic buffer.
- i_ready has no combinational path from o_ready.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- DEPTH, 4, number of storage entries; power of two, >= 2. Elaboration error otherwise.
- BYPASS, 1, 1 = empty FIFO passes i_data to o_data in the same cycle; 0 = registered, minimum latency 1 cycle.
- AF_THRESH, DEPTH-1, almost_full asserted when count >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserted when count <= AE_THRESH.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous clear of contents.
- i_valid  input  1  producer has data.
- i_ready  output  1  FIFO can accept.
- i_data  input  DATA_WIDTH  write payload.
- o_valid  output  1  FIFO presents data.
- o_ready  input  1  consumer accepts.
- o_data  output  DATA_WIDTH  read payload.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.

Behaviour:
- State: storage array (not reset), wr_ptr and rd_ptr of $clog2(DEPTH) bits, count register.
- Pointers wrap DEPTH-1 -> 0 by natural overflow.
- Priority per cycle: rst > flush > normal operation.
- rst asserted (combinational gating while high):
  - i_ready=0 and o_valid=0.
  - Next cycle: wr_ptr=rd_ptr=0, count=0, almost_full=0 (if AF_THRESH>0), almost_empty=1.
- rst mid-operation discards all contents. No handshake completes in a reset cycle.
- flush asserted (combinational gating):
  - i_ready=0 and o_valid=0 in that cycle, so no push or pop completes.
  - Next cycle: pointers=0, count=0.
- i_ready = (count != DEPTH), gated by rst/flush.
- Full boundary: full is a registered condition. A simultaneous pop in the full cycle does not open i_ready that cycle. i_ready rises the cycle after the pop.
- Push = i_valid & i_ready. Pop = o_valid & o_ready.
- Non-bypass path:
  - o_valid = (count != 0), o_data = mem[rd_ptr].
  - Push writes mem[wr_ptr] and increments wr_ptr.
  - Pop increments rd_ptr.
  - count += push - pop, so simultaneous push/pop leaves count unchanged.
- BYPASS=1 and count==0:
  - o_valid = i_valid, o_data = i_data.
  - If o_ready=1, the word passes through. No write, pointers and count unchanged.
  - If o_ready=0, the word is written and count becomes 1.
- BYPASS=0 and count==0: o_valid=0. Written data appears on o_valid the following cycle.
- o_data is don't-care while o_valid=0. The bench must not check it.
- While o_valid=1 and o_ready=0, o_data stays stable until popped.
- Ordering is strict FIFO across pointer wrap.
- Overflow/underflow is impossible by construction.
- Flags are derived from the count register only, so they update the cycle after the push/pop.

Test Plan:
- DATA_WIDTH=8, DEPTH=4, AF_THRESH=3; rst 1 cycle, o_ready=0, push 0x11,0x22,0x33,0x44 -> count 1,2,3,4; almost_full=1 once count=3; i_ready=0 at count=4; a 5th push of 0x55 is held off.
- From full, o_ready=1 for 4 cycles -> o_data 0x11,0x22,0x33,0x44 in order; count 3,2,1,0; i_ready=1 the cycle after the first pop; almost_empty=1 at count<=1.
- count=2, continuous simultaneous push/pop for 6 cycles with data 0x60..0x65 -> count stays 2; output order unbroken across the wrap; rd_ptr and wr_ptr wrap 3->0.
- BYPASS=1, empty, i_valid=1 with 0xA5, o_ready=1 -> o_valid=1 and o_data=0xA5 in the same cycle; count stays 0.
- Repeat the previous case with o_ready=0 -> count=1; next cycle o_data=0xA5.
- BYPASS=0, same stimulus -> o_valid=0 in the push cycle; 0xA5 appears the next cycle.
- count=3, assert flush with i_valid=1 (0x77) -> i_ready=0 and o_valid=0 that cycle; next cycle count=0, o_valid=0; 0x77 is never output.
- count=2, assert rst for 1 cycle while pushing -> count=0 after reset; no pre-reset data is ever output; a subsequent push of 0x12 is output first.
